alu_writeback_stage: RTL and testbench

//   Consumer side of the ALU result/flag interface. Accepts one ALU result per cycle over a

---
 rtl/alu_writeback_stage.sv | 154 +++++++++++++++
 tb/tb_alu_writeback_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// ALU result writeback stage: 2-entry in-order buffer toward the regfile,
// persistent {C,V,N,Z} status register and branch condition evaluation.
module alu_writeback_stage #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_result,
    input  logic                  in_carry,
    input  logic                  in_overflow,
    input  logic                  in_negative,
    input  logic                  in_zero,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wr_en,
    input  logic                  in_set_flags,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_wr_en,
    output logic [3:0]            flags,
    input  logic [2:0]            cond,
    output logic                  cond_true
);

    typedef struct packed {
        logic [WIDTH-1:0]      result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr_en;
    } entry_t;

    entry_t     head;
    entry_t     tail;
    entry_t     head_n;
    entry_t     tail_n;
    entry_t     incoming;
    logic [1:0] count;
    logic [1:0] count_n;
    logic       push;
    logic       pop;

    assign incoming = '{result: in_result, rd: in_rd, wr_en: in_wr_en};

    assign in_ready  = !flush && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head is always slot 0; tail only holds data when two entries are queued.
    always_comb begin
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        if (flush) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = 2'd0;
        end else begin
            unique case (count)
                2'd0: begin
                    if (push) begin
                        head_n  = incoming;
                        count_n = 2'd1;
                    end
                end
                2'd1: begin
                    unique case (1'b1)
                        push && pop: begin
                            head_n = incoming;
                        end
                        push && !pop: begin
                            tail_n  = incoming;
                            count_n = 2'd2;
                        end
                        !push && pop: begin
                            head_n  = '0;
                            count_n = 2'd0;
                        end
                        default: begin
                            head_n = head;
                        end
                    endcase
                end
                2'd2: begin
                    if (pop) begin
                        head_n  = tail;
                        tail_n  = '0;
                        count_n = 2'd1;
                    end
                end
                default: begin
                    head_n  = '0;
                    tail_n  = '0;
                    count_n = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
        end
    end

    // Flags commit at acceptance, so writeback stalls never reorder them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (push && in_set_flags) begin
            flags <= {in_carry, in_overflow, in_negative, in_zero};
        end
    end

    assign out_result = out_valid ? head.result : '0;
    assign out_rd     = out_valid ? head.rd : '0;
    assign out_wr_en  = out_valid && head.wr_en;

    logic flag_c;
    logic flag_v;
    logic flag_n;
    logic flag_z;

    assign flag_c = flags[3];
    assign flag_v = flags[2];
    assign flag_n = flags[1];
    assign flag_z = flags[0];

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = !flag_z;
            3'b011:  cond_true = flag_c;
            3'b100:  cond_true = !flag_c;
            3'b101:  cond_true = flag_n;
            3'b110:  cond_true = (flag_n == flag_v);
            3'b111:  cond_true = (flag_n != flag_v);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: directed corner cases plus a
// randomized phase checked against a queue-based reference model.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic        in_carry;
    logic        in_overflow;
    logic        in_negative;
    logic        in_zero;
    logic [2:0]  in_rd;
    logic        in_wr_en;
    logic        in_set_flags;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    logic        out_wr_en;
    logic [3:0]  flags;
    logic [2:0]  cond;
    logic        cond_true;

    alu_writeback_stage #(.WIDTH(16), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_carry(in_carry),
        .in_overflow(in_overflow), .in_negative(in_negative),
        .in_zero(in_zero), .in_rd(in_rd), .in_wr_en(in_wr_en),
        .in_set_flags(in_set_flags), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
        .flags(flags), .cond(cond), .cond_true(cond_true)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic [2:0]  rd;
        logic        we;
    } exp_t;

    exp_t       q[$];
    logic [3:0] mflags = 4'b0000;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_model(input logic [2:0] c, input logic [3:0] f);
        logic cf, vf, nf, zf;
        {cf, vf, nf, zf} = f;
        case (c)
            3'd0: return 1'b1;
            3'd1: return zf;
            3'd2: return !zf;
            3'd3: return cf;
            3'd4: return !cf;
            3'd5: return nf;
            3'd6: return nf == vf;
            default: return nf != vf;
        endcase
    endfunction

    // Monitor: samples mid-cycle, after the driver has settled inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                chk("in_ready", in_ready, (!flush && q.size() != 2));
                chk("out_valid", out_valid, (q.size() != 0));
                chk("flags", flags, mflags);
                chk("cond_true", cond_true, cond_model(cond, mflags));
                if (q.size() == 0) begin
                    chk("idle_fields", {out_result, out_rd, out_wr_en}, 0);
                end else begin
                    e = q[0];
                    chk("out_result", out_result, e.r);
                    chk("out_rd", out_rd, e.rd);
                    chk("out_wr_en", out_wr_en, e.we);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic idle_inputs();
        in_valid = 0; in_result = 0; in_carry = 0; in_overflow = 0;
        in_negative = 0; in_zero = 0; in_rd = 0; in_wr_en = 0;
        in_set_flags = 0; flush = 0; out_ready = 0; cond = 0;
    endtask

    task automatic drive_entry(input logic [15:0] r, input logic [2:0] rd,
                               input logic sf, input logic [3:0] f);
        in_valid = 1; in_result = r; in_rd = rd; in_wr_en = 1;
        in_set_flags = sf;
        {in_carry, in_overflow, in_negative, in_zero} = f;
    endtask

    localparam int NRAND = 3000;

    initial begin
        bit         pend_push;
        bit         pend_flush;
        bit         pend_sf;
        logic [3:0] pend_f;
        exp_t       pend_e;
        bit         quiet;

        idle_inputs();
        rst_n    = 0;
        in_valid = 1;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", flags, 0);
        chk("rst_cond_al", cond_true, 1);
        repeat (2) @(negedge clk);
        in_valid = 0;
        rst_n    = 1;

        // Single entry with a ready consumer: one-cycle latency then empty.
        @(negedge clk);
        drive_entry(16'h1234, 3'd3, 1'b0, 4'b0000);
        out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("t2_valid", out_valid, 1);
        chk("t2_result", out_result, 16'h1234);
        chk("t2_rd", out_rd, 3);
        @(negedge clk);
        #1;
        chk("t2_drained", out_valid, 0);

        // Stalled consumer: A, B fill the buffer and C is refused.
        @(negedge clk);
        out_ready = 0;
        drive_entry(16'hAAAA, 3'd1, 1'b0, 4'b0000);
        @(negedge clk);
        drive_entry(16'hBBBB, 3'd2, 1'b0, 4'b0000);
        @(negedge clk);
        drive_entry(16'hCCCC, 3'd4, 1'b0, 4'b0000);
        #1;
        chk("t3_full_ready", in_ready, 0);
        @(negedge clk);
        in_valid  = 0;
        out_ready = 1;
        #1;
        chk("t3_head_a", out_result, 16'hAAAA);
        @(negedge clk);
        #1;
        chk("t3_head_b", out_result, 16'hBBBB);
        @(negedge clk);
        #1;
        chk("t3_empty", out_valid, 0);

        // Randomized phase against the queue model.
        q.delete();
        mflags     = 4'b0000;
        pend_push  = 0;
        pend_flush = 0;
        pend_sf    = 0;
        pend_f     = 0;
        pend_e     = '{r: 0, rd: 0, we: 0};
        @(negedge clk);
        mon_en = 1;
        for (int i = 0; i < NRAND; i++) begin
            if (i != 0) @(negedge clk);
            if (pend_flush) q.delete();
            if (pend_push) begin
                q.push_back(pend_e);
                if (pend_sf) mflags = pend_f;
            end
            quiet        = (i >= NRAND - 6);
            flush        = !quiet && ($urandom_range(15) == 0);
            in_valid     = !quiet && ($urandom_range(3) != 0);
            out_ready    = quiet || ($urandom_range(3) < ((i / 200) % 4));
            in_result    = 16'($urandom);
            in_rd        = 3'($urandom);
            in_wr_en     = 1'($urandom);
            in_set_flags = 1'($urandom);
            {in_carry, in_overflow, in_negative, in_zero} = 4'($urandom);
            cond         = 3'($urandom);
            pend_flush   = flush;
            pend_push    = in_valid && !flush && (q.size() != 2);
            pend_sf      = in_set_flags;
            pend_f       = {in_carry, in_overflow, in_negative, in_zero};
            pend_e       = '{r: in_result, rd: in_rd, we: in_wr_en};
        end
        @(negedge clk);
        mon_en = 0;
        idle_inputs();
        #1;
        chk("rand_drained", out_valid, 0);

        // Flag commit and condition codes; a set_flags=0 entry leaves flags.
        @(negedge clk);
        drive_entry(16'h0101, 3'd5, 1'b1, 4'b1010);
        @(negedge clk);
        drive_entry(16'h0202, 3'd6, 1'b0, 4'b0001);
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("t4_flags", flags, 4'b1010);
        chk("t4_full", in_ready, 0);
        cond = 3'b101;
        #1 chk("t4_mi", cond_true, 1);
        cond = 3'b110;
        #1 chk("t4_ge", cond_true, 0);
        cond = 3'b111;
        #1 chk("t4_lt", cond_true, 1);

        // Flush with count=2 and a valid incoming entry.
        @(negedge clk);
        flush = 1;
        drive_entry(16'hDEAD, 3'd7, 1'b1, 4'b0101);
        #1;
        chk("t5_in_ready", in_ready, 0);
        @(negedge clk);
        flush    = 0;
        in_valid = 0;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_flags", flags, 4'b1010);

        // Asynchronous reset while full.
        @(negedge clk);
        drive_entry(16'h1111, 3'd1, 1'b1, 4'b0110);
        @(negedge clk);
        drive_entry(16'h2222, 3'd2, 1'b0, 4'b0000);
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_flags", flags, 4'b0110);
        rst_n = 0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_flags", flags, 0);
        chk("t6_result", out_result, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("t6_after", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
